// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
//  alu_exec_unit_if : operation/result handshake bundle for alu_exec_unit
//  Revision: 1.0
// ============================================================================
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operacioni;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             op_err;
  logic             busy;

  modport master (
    output in_valid, operacioni, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry_out, overflow, op_err, busy
  );

  modport slave (
    input  in_valid, operacioni, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry_out, overflow, op_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  alu_exec_unit : handshaked ALU stage, single-cycle ops plus 1-bit/cycle shifts
//  Revision: 1.0
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_SLT  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_SUBI = 4'b1101;

  localparam logic [SHAMT_W-1:0] C_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_sra;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;
  logic               r_operr;

  logic               w_accept;
  logic               w_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_result;
  logic               w_carry;
  logic               w_ovf;
  logic               w_operr;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_shift_next;

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry_out = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.op_err    = r_operr;

  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_shamt      = bus.b[SHAMT_W-1:0];
  assign w_is_shift   = (bus.operacioni == OP_SLL) || (bus.operacioni == OP_SRA);
  assign w_shift_next = r_sra ? {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]}
                              : {r_shreg[WIDTH-2:0], 1'b0};

  // One adder serves ADD and SUB/SUBI: subtraction is A + ~B + 1.
  always_comb begin
    w_sub    = (bus.operacioni == OP_SUB) || (bus.operacioni == OP_SUBI);
    w_b_eff  = w_sub ? ~bus.b : bus.b;
    w_sum    = {1'b0, bus.a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    w_result = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    w_operr  = 1'b0;
    case (bus.operacioni)
      OP_AND: w_result = bus.a & bus.b;
      OP_OR:  w_result = bus.a | bus.b;
      OP_XOR: w_result = bus.a ^ bus.b;
      OP_ADD, OP_SUB, OP_SUBI: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
        w_ovf    = (bus.a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      // Only reached as a result when the shift amount is zero.
      OP_SLL, OP_SRA: w_result = bus.a;
      default: w_operr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_sra    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_operr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_shreg <= bus.a;
              r_cnt   <= w_shamt;
              r_sra   <= (bus.operacioni == OP_SRA);
              r_state <= S_SHIFT;
            end else begin
              r_result <= w_result;
              r_zero   <= (w_result == '0);
              r_carry  <= w_carry;
              r_ovf    <= w_ovf;
              r_operr  <= w_operr;
              r_state  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_shreg <= w_shift_next;
          r_cnt   <= r_cnt - C_CNT_ONE;
          if (r_cnt == C_CNT_ONE) begin
            r_result <= w_shift_next;
            r_zero   <= (w_shift_next == '0);
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_operr  <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
